alu_op_controller: RTL

Multi-cycle sequencer for LC-3 operate instructions (ADD, AND, NOT). It accepts an instruction word over a valid/ready handshake, decodes it into register-file addresses, the SR2 mux select, sign-extended imm5 and the ALUK code. It then requests the shared system bus and, once granted, drives GateALU together with the register and condition-code load strobes for exactly one cycle. It sits between the IR/fetch logic and the ALU, register file and bus arbiter.

---
 rtl/lc3_ctrl_pkg.sv | 21 ++
 rtl/alu_op_controller_op_decode.sv | 44 ++++
 rtl/alu_op_controller.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/lc3_ctrl_pkg.sv
// Shared constants and state encoding for the LC-3 operate-instruction controller.
package lc3_ctrl_pkg;

   localparam logic [3:0] OP_ADD = 4'b0001;
   localparam logic [3:0] OP_AND = 4'b0101;
   localparam logic [3:0] OP_NOT = 4'b1001;

   localparam logic [1:0] ALUK_ADD  = 2'b00;
   localparam logic [1:0] ALUK_AND  = 2'b01;
   localparam logic [1:0] ALUK_NOT  = 2'b10;
   localparam logic [1:0] ALUK_PASS = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_DECODE = 3'd1,
      ST_REQ    = 3'd2,
      ST_EXEC   = 3'd3,
      ST_DONE   = 3'd4
   } state_t;

endpackage

// File: rtl/alu_op_controller_op_decode.sv
// Combinational field extraction and legality check for ADD/AND/NOT encodings.
module op_decode
   import lc3_ctrl_pkg::*;
(
   input  logic [15:0] i_instr,
   output logic [2:0]  o_sr1,
   output logic [2:0]  o_sr2,
   output logic [2:0]  o_dr,
   output logic        o_sr2mux_sel,
   output logic [15:0] o_imm5_sext,
   output logic [1:0]  o_aluk,
   output logic        o_legal
);

   always_comb begin
      o_sr1        = i_instr[8:6];
      o_sr2        = i_instr[2:0];
      o_dr         = i_instr[11:9];
      o_sr2mux_sel = i_instr[5];
      o_imm5_sext  = {{11{i_instr[4]}}, i_instr[4:0]};
      o_aluk       = ALUK_ADD;
      o_legal      = 1'b0;
      // Register-mode ADD/AND must keep bits [4:3] clear; illegal words never select PASS.
      case (i_instr[15:12])
         OP_ADD: begin
            o_aluk  = ALUK_ADD;
            o_legal = i_instr[5] | (i_instr[4:3] == 2'b00);
         end
         OP_AND: begin
            o_aluk  = ALUK_AND;
            o_legal = i_instr[5] | (i_instr[4:3] == 2'b00);
         end
         OP_NOT: begin
            o_aluk  = ALUK_NOT;
            o_legal = (i_instr[5:0] == 6'b111111);
         end
         default: begin
            o_aluk  = ALUK_ADD;
            o_legal = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/alu_op_controller.sv
// Multi-cycle sequencer for LC-3 ADD/AND/NOT: accept, decode, request bus, execute, retire.
module alu_op_controller
   import lc3_ctrl_pkg::*;
#(
   parameter int GNT_TIMEOUT = 15,
   parameter int CNT_W       = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        instr_valid,
   output logic        instr_ready,
   input  logic [15:0] instr,
   output logic        bus_req,
   input  logic        bus_gnt,
   output logic [2:0]  sr1,
   output logic [2:0]  sr2,
   output logic [2:0]  dr,
   output logic        sr2mux_sel,
   output logic [15:0] imm5_sext,
   output logic [1:0]  aluk,
   output logic        gate_alu,
   output logic        ld_reg,
   output logic        ld_cc,
   output logic        done,
   output logic        illegal,
   output logic        timeout,
   output logic        busy
);

   localparam logic [CNT_W-1:0] TMO     = CNT_W'(GNT_TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [2:0]       w_sr1, w_sr2, w_dr;
   logic             w_sel, w_legal;
   logic [15:0]      w_imm;
   logic [1:0]       w_aluk;
   logic [CNT_W-1:0] w_cnt_nxt;

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_legal;

   op_decode u_dec (
      .i_instr      (instr),
      .o_sr1        (w_sr1),
      .o_sr2        (w_sr2),
      .o_dr         (w_dr),
      .o_sr2mux_sel (w_sel),
      .o_imm5_sext  (w_imm),
      .o_aluk       (w_aluk),
      .o_legal      (w_legal)
   );

   assign w_cnt_nxt = r_cnt + CNT_ONE;

   // Outputs are driven as next-state values so each one is visible during the state it belongs to.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_legal     <= 1'b0;
         instr_ready <= 1'b1;
         bus_req     <= 1'b0;
         sr1         <= 3'd0;
         sr2         <= 3'd0;
         dr          <= 3'd0;
         sr2mux_sel  <= 1'b0;
         imm5_sext   <= 16'd0;
         aluk        <= ALUK_ADD;
         gate_alu    <= 1'b0;
         ld_reg      <= 1'b0;
         ld_cc       <= 1'b0;
         done        <= 1'b0;
         illegal     <= 1'b0;
         timeout     <= 1'b0;
         busy        <= 1'b0;
      end else begin
         done    <= 1'b0;
         illegal <= 1'b0;
         timeout <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (instr_valid) begin
                  sr1         <= w_sr1;
                  sr2         <= w_sr2;
                  dr          <= w_dr;
                  sr2mux_sel  <= w_sel;
                  imm5_sext   <= w_imm;
                  aluk        <= w_aluk;
                  r_legal     <= w_legal;
                  illegal     <= ~w_legal;
                  instr_ready <= 1'b0;
                  busy        <= 1'b1;
                  r_state     <= ST_DECODE;
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            ST_DECODE: begin
               if (r_legal) begin
                  bus_req <= 1'b1;
                  r_state <= ST_REQ;
               end else begin
                  instr_ready <= 1'b1;
                  busy        <= 1'b0;
                  r_state     <= ST_IDLE;
               end
            end
            ST_REQ: begin
               if (bus_gnt) begin
                  gate_alu <= 1'b1;
                  ld_reg   <= 1'b1;
                  ld_cc    <= 1'b1;
                  r_cnt    <= '0;
                  r_state  <= ST_EXEC;
               end else if ((GNT_TIMEOUT != 0) && (w_cnt_nxt == TMO)) begin
                  timeout     <= 1'b1;
                  bus_req     <= 1'b0;
                  instr_ready <= 1'b1;
                  busy        <= 1'b0;
                  r_cnt       <= '0;
                  r_state     <= ST_IDLE;
               end else begin
                  r_cnt <= w_cnt_nxt;
               end
            end
            ST_EXEC: begin
               gate_alu <= 1'b0;
               ld_reg   <= 1'b0;
               ld_cc    <= 1'b0;
               bus_req  <= 1'b0;
               done     <= 1'b1;
               r_state  <= ST_DONE;
            end
            ST_DONE: begin
               instr_ready <= 1'b1;
               busy        <= 1'b0;
               r_state     <= ST_IDLE;
            end
            default: begin
               gate_alu    <= 1'b0;
               ld_reg      <= 1'b0;
               ld_cc       <= 1'b0;
               bus_req     <= 1'b0;
               instr_ready <= 1'b1;
               busy        <= 1'b0;
               r_cnt       <= '0;
               r_state     <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
